// File: rtl/fifo_word_assembler.sv
// Packs WORDS consecutive FIFO items into one wide word offered over valid/ready.
// Optional registered parity output enabled by defining FIFO_ASM_PARITY_EN.
module fifo_word_assembler #(
    parameter int unsigned SIZE  = 2,
    parameter int unsigned WORDS = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    fifo_empty,
    input  logic [SIZE-1:0]         fifo_item,
    output logic                    fifo_read,
    output logic [WORDS*SIZE-1:0]   word_out,
    output logic                    word_valid,
    input  logic                    word_ready,
`ifdef FIFO_ASM_PARITY_EN
    output logic                    word_parity,
`endif
    output logic [7:0]              words_done
);

    localparam int unsigned WORD_W = WORDS * SIZE;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_OUT  = 1'b1;

    logic [0:0]        state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [WORD_W-1:0] word_nxt;
    logic              valid_nxt;
    logic [7:0]        done_nxt;
`ifdef FIFO_ASM_PARITY_EN
    logic              parity_nxt;
`endif

    // Pop straight off the FIFO head while filling; never while a word is pending.
    assign fifo_read = (state == ST_FILL) & ~fifo_empty & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_FILL;
            idx         <= '0;
            word_out    <= '0;
            word_valid  <= 1'b0;
            words_done  <= '0;
`ifdef FIFO_ASM_PARITY_EN
            word_parity <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            word_out    <= word_nxt;
            word_valid  <= valid_nxt;
            words_done  <= done_nxt;
`ifdef FIFO_ASM_PARITY_EN
            word_parity <= parity_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        word_nxt   = word_out;
        valid_nxt  = word_valid;
        done_nxt   = words_done;
`ifdef FIFO_ASM_PARITY_EN
        parity_nxt = word_parity;
`endif
        if (state == ST_FILL) begin
            if (fifo_read) begin
                for (int unsigned i = 0; i < WORDS; i++) begin
                    if (idx == IDX_W'(i)) begin
                        word_nxt[i*SIZE +: SIZE] = fifo_item;
                    end
                end
                if (idx == IDX_W'(WORDS - 1)) begin
                    idx_nxt    = '0;
                    state_nxt  = ST_OUT;
                    valid_nxt  = 1'b1;
`ifdef FIFO_ASM_PARITY_EN
                    parity_nxt = ^word_nxt;
`endif
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
        end else begin
            // Word held until the downstream stage takes it.
            if (word_ready) begin
                valid_nxt = 1'b0;
                state_nxt = ST_FILL;
                done_nxt  = words_done + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_assembler.sv
// Self-checking bench for fifo_word_assembler: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_fifo_word_assembler;

    localparam int unsigned SIZE  = 2;
    localparam int unsigned WORDS = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned WW    = SIZE * WORDS;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            fifo_empty;
    logic [SIZE-1:0] fifo_item;
    logic            fifo_read;
    logic [WW-1:0]   word_out;
    logic            word_valid;
    logic            word_ready;
    logic [7:0]      words_done;
`ifdef FIFO_ASM_PARITY_EN
    logic            word_parity;
`endif

    always #5 clk = ~clk;

    fifo_word_assembler #(.SIZE(SIZE), .WORDS(WORDS), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fifo_empty (fifo_empty),
        .fifo_item  (fifo_item),
        .fifo_read  (fifo_read),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
`ifdef FIFO_ASM_PARITY_EN
        .word_parity(word_parity),
`endif
        .words_done (words_done)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model state: pending FIFO contents, items gathered so far, pending word.
    int unsigned fifo_q[$];
    int unsigned acc[$];
    bit          pending;
    int unsigned exp_word;
    int unsigned exp_done;
    logic [WW-1:0] last_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int unsigned v);
        fifo_q.push_back(v);
    endtask

    task automatic model_reset();
        fifo_q.delete();
        acc.delete();
        pending  = 1'b0;
        exp_word = 0;
        exp_done = 0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit avail, input bit rdy);
        bit exp_read;
        fifo_empty = !(avail && fifo_q.size() > 0);
        fifo_item  = (fifo_q.size() > 0) ? SIZE'(fifo_q[0]) : SIZE'($urandom);
        word_ready = rdy;
        exp_read   = !pending && !fifo_empty;
        #1 chk("fifo_read", {31'b0, fifo_read}, {31'b0, exp_read});
        @(posedge clk);
        if (pending && rdy) begin
            pending  = 1'b0;
            exp_done = (exp_done + 1) % 256;
        end else if (exp_read) begin
            acc.push_back(fifo_q.pop_front());
            if (acc.size() == WORDS) begin
                exp_word = 0;
                foreach (acc[k]) exp_word += acc[k] << (SIZE * k);
                acc.delete();
                pending = 1'b1;
            end
        end
        @(negedge clk);
        chk("word_valid", {31'b0, word_valid}, {31'b0, pending});
        chk("words_done", {24'b0, words_done}, exp_done);
        if (pending) begin
            chk("word_out", {24'b0, word_out}, exp_word);
            last_word = word_out;
`ifdef FIFO_ASM_PARITY_EN
            chk("word_parity", {31'b0, word_parity}, $countones(exp_word) % 2);
`endif
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        fifo_empty = 1'b0;
        fifo_item  = 2'd1;
        word_ready = 1'b1;
        #1;
        chk("rst_fifo_read", {31'b0, fifo_read}, 0);
        chk("rst_word_valid", {31'b0, word_valid}, 0);
        chk("rst_word_out", {24'b0, word_out}, 0);
        chk("rst_words_done", {24'b0, words_done}, 0);
`ifdef FIFO_ASM_PARITY_EN
        chk("rst_word_parity", {31'b0, word_parity}, 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n    = 1'b0;
        fifo_empty = 1'b1;
        fifo_item  = '0;
        word_ready = 1'b0;
        last_word  = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Streaming with ready high: 1,2,3,0 -> 0x39
        push(1); push(2); push(3); push(0);
        repeat (4) step(1'b1, 1'b1);
        chk("stream_word", {24'b0, last_word}, 32'h39);
        push(2);
        step(1'b1, 1'b1);
        chk("stream_done", {24'b0, words_done}, 1);

        // Backpressure: word held five cycles with the FIFO non-empty
        push(3); push(1); push(0); push(1); push(1);
        repeat (3) step(1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("bp_done", {24'b0, words_done}, 2);

        // Empty stall mid-fill: 1,2 then gap then 3,3 -> 0xF9
        do_reset();
        push(1); push(2);
        repeat (2) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        push(3); push(3);
        repeat (2) step(1'b1, 1'b0);
        chk("stall_word", {24'b0, last_word}, 32'hF9);
        step(1'b1, 1'b1);

        // Reset mid-fill discards partial items
        do_reset();
        push(1); push(3);
        repeat (2) step(1'b1, 1'b0);
        do_reset();
        push(2); push(2); push(2); push(2);
        repeat (4) step(1'b1, 1'b1);
        chk("rstmid_word", {24'b0, last_word}, 32'hAA);
        step(1'b1, 1'b1);
        chk("rstmid_done", {24'b0, words_done}, 1);
        repeat (3) step(1'b1, 1'b1);
        chk("rstmid_single", {24'b0, words_done}, 1);

        // Random traffic, stalls and backpressure
        do_reset();
        repeat (400) begin
            if ($urandom_range(0, 2) != 0) push($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        end

        // Counter wrap after 256 words
        do_reset();
        repeat (256) begin
            repeat (4) push($urandom_range(0, 3));
            repeat (5) step(1'b1, 1'b1);
        end
        chk("wrap_done", {24'b0, words_done}, 0);

`ifdef FIFO_ASM_PARITY_EN
        do_reset();
        push(1); push(2); push(3); push(0);
        repeat (4) step(1'b1, 1'b0);
        chk("parity_39", {31'b0, word_parity}, 0);
        step(1'b1, 1'b1);
        push(0); push(2); push(3); push(0);
        repeat (4) step(1'b1, 1'b0);
        chk("parity_38", {31'b0, word_parity}, 1);
        step(1'b1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
